// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared datapath types for the scalar functional-unit status
//               tables.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RDY   = 2'd2,
        ST_EX    = 2'd3
    } fust_state_e;

    // Packed row layout, sized by the instantiating table's parameters.
    // A package cannot take parameters, so the table declares
    // row_t itself using these field names in this order.
    localparam int ROW_FIELDS = 9;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N; i++) begin
            logic [IDX_W-1:0] w_j;
            w_j = IDX_W'((int'(ptr) + i) % N);
            if (!gnt_valid && req[w_j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_j;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fust_s_gen.sv
`default_nettype none
// ============================================================================
// Module      : fust_s_gen
// Description : Parametrised scalar FU status table with tag wakeup,
//               round-robin issue and branch-mispredict squash.
// Revision    : 1.0 - initial release
// ============================================================================
module fust_s_gen
    import datapath_pkg::*;
#(
    parameter int NUM_FU   = 3,
    parameter int FU_IDX_W = $clog2(NUM_FU),
    parameter int TAG_W    = $clog2(NUM_FU + 1),
    parameter int REG_W    = 5,
    parameter int IMM_W    = 32,
    parameter int OP_W     = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                dis_en,
    input  logic [FU_IDX_W-1:0] dis_fu,
    input  logic [REG_W-1:0]    dis_rd,
    input  logic [REG_W-1:0]    dis_rs1,
    input  logic [REG_W-1:0]    dis_rs2,
    input  logic [IMM_W-1:0]    dis_imm,
    input  logic [OP_W-1:0]     dis_op,
    input  logic                dis_spec,
    input  logic [TAG_W-1:0]    dis_t1,
    input  logic [TAG_W-1:0]    dis_t2,
    input  logic [NUM_FU-1:0]   wb_valid,
    input  logic [NUM_FU-1:0]   fu_ready,
    input  logic [NUM_FU-1:0]   fu_done,
    input  logic                br_resolved,
    input  logic                br_miss,
    output logic [NUM_FU-1:0]   busy,
    output logic                iss_valid,
    output logic [FU_IDX_W-1:0] iss_fu,
    output logic [REG_W-1:0]    iss_rd,
    output logic [REG_W-1:0]    iss_rs1,
    output logic [REG_W-1:0]    iss_rs2,
    output logic [IMM_W-1:0]    iss_imm,
    output logic [OP_W-1:0]     iss_op,
    output logic                iss_spec,
    output logic                dis_err
);

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
        logic [OP_W-1:0]  op;
        logic             spec;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        fust_state_e      state;
    } row_t;

    localparam logic [TAG_W-1:0]    c_max_tag = TAG_W'(NUM_FU);
    localparam logic [FU_IDX_W-1:0] c_last    = FU_IDX_W'(NUM_FU - 1);

    row_t                r_row     [NUM_FU];
    row_t                w_row_nxt [NUM_FU];
    logic [FU_IDX_W-1:0] r_ptr;
    logic                r_dis_err;
    logic                w_dis_err;
    logic                w_hit;
    logic                w_drop;
    logic [NUM_FU-1:0]   w_req;
    logic                w_gnt_valid;
    logic [FU_IDX_W-1:0] w_gnt_idx;

    // Tag k means "waiting on FU k-1"; a matching broadcast clears it.
    function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0] t,
                                              input logic [NUM_FU-1:0] wb);
        logic [TAG_W-1:0] r;
        r = t;
        for (int k = 0; k < NUM_FU; k++) begin
            if (t == TAG_W'(k + 1) && wb[k]) r = '0;
        end
        return r;
    endfunction

    for (genvar g = 0; g < NUM_FU; g++) begin : g_row_flags
        assign busy[g]  = (r_row[g].state != ST_EMPTY);
        assign w_req[g] = (r_row[g].state == ST_RDY) && fu_ready[g];
    end

    rr_arbiter #(
        .N     (NUM_FU),
        .IDX_W (FU_IDX_W)
    ) u_arb (
        .req       (w_req),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_drop = br_miss && dis_spec;

    always_comb begin
        w_dis_err = 1'b0;
        w_hit     = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_row_nxt[k]    = r_row[k];
            w_row_nxt[k].t1 = wake(r_row[k].t1, wb_valid);
            w_row_nxt[k].t2 = wake(r_row[k].t2, wb_valid);
            case (r_row[k].state)
                ST_WAIT: if (w_row_nxt[k].t1 == '0 && w_row_nxt[k].t2 == '0)
                             w_row_nxt[k].state = ST_RDY;
                ST_RDY:  if (w_gnt_valid && w_gnt_idx == FU_IDX_W'(k))
                             w_row_nxt[k].state = ST_EX;
                ST_EX:   if (fu_done[k]) w_row_nxt[k] = '0;
                default: ;
            endcase
            if (br_resolved) w_row_nxt[k].spec = 1'b0;
            // Squash wins over resolve and over any grant this cycle.
            if (br_miss && r_row[k].spec) w_row_nxt[k] = '0;
            if (dis_en && dis_fu == FU_IDX_W'(k)) begin
                w_hit = 1'b1;
                if (!w_drop) begin
                    if (r_row[k].state == ST_EMPTY ||
                        (r_row[k].state == ST_EX && fu_done[k])) begin
                        w_row_nxt[k].rd    = dis_rd;
                        w_row_nxt[k].rs1   = dis_rs1;
                        w_row_nxt[k].rs2   = dis_rs2;
                        w_row_nxt[k].imm   = dis_imm;
                        w_row_nxt[k].op    = dis_op;
                        w_row_nxt[k].spec  = dis_spec;
                        w_row_nxt[k].t1    = wake(dis_t1, wb_valid);
                        w_row_nxt[k].t2    = wake(dis_t2, wb_valid);
                        w_row_nxt[k].state = (w_row_nxt[k].t1 == '0 &&
                                              w_row_nxt[k].t2 == '0) ? ST_RDY : ST_WAIT;
                    end else begin
                        w_dis_err = 1'b1;
                    end
                end
            end
        end
        // A dispatch index beyond the table has no row to land in.
        if (dis_en && !w_hit && !w_drop) w_dis_err = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NUM_FU; k++) r_row[k] <= '0;
            r_ptr     <= '0;
            r_dis_err <= 1'b0;
        end else begin
            r_row     <= w_row_nxt;
            r_dis_err <= w_dis_err;
            if (w_gnt_valid) r_ptr <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_comb begin
        iss_valid = w_gnt_valid;
        iss_fu    = '0;
        iss_rd    = '0;
        iss_rs1   = '0;
        iss_rs2   = '0;
        iss_imm   = '0;
        iss_op    = '0;
        iss_spec  = 1'b0;
        if (w_gnt_valid) begin
            iss_fu   = w_gnt_idx;
            iss_rd   = r_row[w_gnt_idx].rd;
            iss_rs1  = r_row[w_gnt_idx].rs1;
            iss_rs2  = r_row[w_gnt_idx].rs2;
            iss_imm  = r_row[w_gnt_idx].imm;
            iss_op   = r_row[w_gnt_idx].op;
            iss_spec = r_row[w_gnt_idx].spec;
        end
    end

    assign dis_err = r_dis_err;

    a_tag_legal: assert property (@(posedge CLK) disable iff (!nRST)
        dis_en |-> (dis_t1 <= c_max_tag && dis_t2 <= c_max_tag));

endmodule : fust_s_gen
`default_nettype wire

// File: tb/tb_fust_s_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fust_s_gen
// Description : Directed self-checking bench for fust_s_gen (3- and 5-row).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fust_s_gen;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    // 3-row instance
    logic        dis_en, dis_spec, br_resolved, br_miss;
    logic [1:0]  dis_fu, dis_t1, dis_t2;
    logic [4:0]  dis_rd, dis_rs1, dis_rs2;
    logic [31:0] dis_imm;
    logic [3:0]  dis_op;
    logic [2:0]  wb_valid, fu_ready, fu_done, busy;
    logic        iss_valid, iss_spec, dis_err;
    logic [1:0]  iss_fu;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [31:0] iss_imm;
    logic [3:0]  iss_op;

    // 5-row instance
    logic        b_dis_en, b_dis_spec, b_iss_valid, b_iss_spec, b_dis_err;
    logic [2:0]  b_dis_fu, b_dis_t1, b_dis_t2, b_iss_fu;
    logic [4:0]  b_wb_valid, b_fu_ready, b_fu_done, b_busy;
    logic [4:0]  b_iss_rd, b_iss_rs1, b_iss_rs2;
    logic [31:0] b_iss_imm;
    logic [3:0]  b_iss_op;

    int n_checks = 0;
    int n_errors = 0;

    fust_s_gen #(.NUM_FU(3)) u_dut3 (
        .CLK(clk), .nRST(nRST), .dis_en(dis_en), .dis_fu(dis_fu),
        .dis_rd(dis_rd), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2), .dis_imm(dis_imm),
        .dis_op(dis_op), .dis_spec(dis_spec), .dis_t1(dis_t1), .dis_t2(dis_t2),
        .wb_valid(wb_valid), .fu_ready(fu_ready), .fu_done(fu_done),
        .br_resolved(br_resolved), .br_miss(br_miss), .busy(busy),
        .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .iss_imm(iss_imm), .iss_op(iss_op), .iss_spec(iss_spec),
        .dis_err(dis_err)
    );

    fust_s_gen #(.NUM_FU(5)) u_dut5 (
        .CLK(clk), .nRST(nRST), .dis_en(b_dis_en), .dis_fu(b_dis_fu),
        .dis_rd(5'd0), .dis_rs1(5'd0), .dis_rs2(5'd0), .dis_imm(32'd0),
        .dis_op(4'd0), .dis_spec(b_dis_spec), .dis_t1(b_dis_t1), .dis_t2(b_dis_t2),
        .wb_valid(b_wb_valid), .fu_ready(b_fu_ready), .fu_done(b_fu_done),
        .br_resolved(1'b0), .br_miss(1'b0), .busy(b_busy),
        .iss_valid(b_iss_valid), .iss_fu(b_iss_fu), .iss_rd(b_iss_rd),
        .iss_rs1(b_iss_rs1), .iss_rs2(b_iss_rs2), .iss_imm(b_iss_imm),
        .iss_op(b_iss_op), .iss_spec(b_iss_spec), .dis_err(b_dis_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic disp(input logic [1:0] fu, input logic [4:0] rd, input logic [31:0] imm,
                        input logic spec, input logic [1:0] t1, input logic [1:0] t2);
        dis_en = 1'b1; dis_fu = fu; dis_rd = rd; dis_imm = imm;
        dis_spec = spec; dis_t1 = t1; dis_t2 = t2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        dis_en = 0; dis_fu = 0; dis_rd = 0; dis_rs1 = 5'd1; dis_rs2 = 5'd2;
        dis_imm = 0; dis_op = 4'd3; dis_spec = 0; dis_t1 = 0; dis_t2 = 0;
        wb_valid = 0; fu_ready = 3'b111; fu_done = 0; br_resolved = 0; br_miss = 0;
        b_dis_en = 0; b_dis_fu = 0; b_dis_spec = 0; b_dis_t1 = 0; b_dis_t2 = 0;
        b_wb_valid = 0; b_fu_ready = 0; b_fu_done = 0;
        tick(); tick();
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_iss_valid", 64'(iss_valid), 64'h0);
        chk("reset_iss_imm", 64'(iss_imm), 64'h0);
        chk("reset_dis_err", 64'(dis_err), 64'h0);
        nRST = 1'b1;

        // Ready-operand dispatch, issue next cycle, release on fu_done
        disp(2'd1, 5'd5, 32'h1234, 1'b0, 2'd0, 2'd0);
        tick(); dis_en = 0;
        chk("t1_busy", 64'(busy), 64'h2);
        chk("t1_iss_valid", 64'(iss_valid), 64'h1);
        chk("t1_iss_fu", 64'(iss_fu), 64'h1);
        chk("t1_iss_imm", 64'(iss_imm), 64'h1234);
        chk("t1_iss_rd", 64'(iss_rd), 64'h5);
        tick();
        chk("t1_ex_no_issue", 64'(iss_valid), 64'h0);
        fu_done = 3'b010; tick(); fu_done = 0;
        chk("t1_release", 64'(busy), 64'h0);

        // Dependent dispatch waiting on FU1
        disp(2'd0, 5'd6, 32'h0, 1'b0, 2'd2, 2'd0);
        tick(); dis_en = 0;
        chk("t2_wait_busy", 64'(busy), 64'h1);
        chk("t2_wait_iss0", 64'(iss_valid), 64'h0);
        tick();
        wb_valid = 3'b010; settle();
        chk("t2_wait_iss1", 64'(iss_valid), 64'h0);
        tick(); wb_valid = 0;
        chk("t2_wake_iss", 64'(iss_valid), 64'h1);
        chk("t2_wake_fu", 64'(iss_fu), 64'h0);
        tick(); fu_done = 3'b001; tick(); fu_done = 0;

        // Fill all rows, then reset asynchronously mid-operation
        fu_ready = 0;
        for (int i = 0; i < 3; i++) begin disp(2'(i), 5'd0, 32'h0, 1'b0, 2'd0, 2'd0); tick(); end
        dis_en = 0;
        chk("t3_full", 64'(busy), 64'h7);
        #2 nRST = 1'b0; #1;
        chk("t3_async_rst", 64'(busy), 64'h0);
        nRST = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin disp(2'(i), 5'd0, 32'h0, 1'b0, 2'd0, 2'd0); tick(); end
        dis_en = 0;
        fu_ready = 3'b111; settle();
        chk("t3_gnt0", 64'(iss_fu), 64'h0);
        tick();
        chk("t3_gnt1", 64'(iss_fu), 64'h1);
        tick();
        chk("t3_gnt2", 64'(iss_fu), 64'h2);
        tick();
        chk("t3_all_ex", 64'(iss_valid), 64'h0);
        fu_done = 3'b111; fu_ready = 0; tick(); fu_done = 0;
        disp(2'd2, 5'd0, 32'h0, 1'b0, 2'd0, 2'd0); tick();
        disp(2'd0, 5'd0, 32'h0, 1'b0, 2'd0, 2'd0); tick(); dis_en = 0;
        fu_ready = 3'b111; settle();
        chk("t3_wrap_gnt0", 64'(iss_fu), 64'h0);
        tick();
        chk("t3_next_gnt2", 64'(iss_fu), 64'h2);
        tick(); fu_ready = 0; fu_done = 3'b101; tick(); fu_done = 0;

        // Speculation: squash, drop, resolve
        disp(2'd0, 5'd3, 32'h0, 1'b1, 2'd0, 2'd0); tick();
        disp(2'd2, 5'd7, 32'h77, 1'b0, 2'd0, 2'd0); tick(); dis_en = 0;
        fu_ready = 3'b001; settle();
        chk("t4_spec_bit", 64'(iss_spec), 64'h1);
        fu_ready = 0;
        br_miss = 1; disp(2'd1, 5'd4, 32'h0, 1'b1, 2'd0, 2'd0);
        tick(); br_miss = 0; dis_en = 0;
        chk("t4_squash_busy", 64'(busy), 64'h4);
        chk("t4_drop_no_err", 64'(dis_err), 64'h0);
        disp(2'd0, 5'd3, 32'h0, 1'b1, 2'd0, 2'd0); tick(); dis_en = 0;
        br_miss = 1; br_resolved = 1; tick(); br_miss = 0; br_resolved = 0;
        chk("t4_miss_wins", 64'(busy), 64'h4);
        disp(2'd0, 5'd3, 32'h0, 1'b1, 2'd0, 2'd0); tick(); dis_en = 0;
        br_resolved = 1; tick(); br_resolved = 0;
        chk("t4_resolved_busy", 64'(busy), 64'h5);
        br_miss = 1; tick(); br_miss = 0;
        chk("t4_miss_after_res", 64'(busy), 64'h5);
        fu_ready = 3'b001; settle();
        chk("t4_spec_cleared", 64'(iss_spec), 64'h0);
        chk("t4_iss_fu", 64'(iss_fu), 64'h0);
        tick(); fu_ready = 0;

        // Dispatch to occupied row, then with same-cycle release
        disp(2'd2, 5'd9, 32'hABCD, 1'b0, 2'd0, 2'd0); tick(); dis_en = 0;
        chk("t5_reject_err", 64'(dis_err), 64'h1);
        fu_ready = 3'b100; settle();
        chk("t5_row_kept_fu", 64'(iss_fu), 64'h2);
        chk("t5_row_kept_rd", 64'(iss_rd), 64'h7);
        tick(); fu_ready = 0;
        chk("t5_err_pulse", 64'(dis_err), 64'h0);
        disp(2'd2, 5'd9, 32'hABCD, 1'b0, 2'd0, 2'd0); fu_done = 3'b100;
        tick(); dis_en = 0; fu_done = 0;
        chk("t5_accept_err", 64'(dis_err), 64'h0);
        chk("t5_accept_busy", 64'(busy), 64'h5);
        fu_ready = 3'b100; settle();
        chk("t5_accept_rd", 64'(iss_rd), 64'h9);
        chk("t5_accept_imm", 64'(iss_imm), 64'hABCD);
        fu_ready = 0;

        // 5-row build: tag 5 waits on FU4, same-cycle wakeup on dispatch
        b_dis_en = 1; b_dis_fu = 3'd3; b_dis_t1 = 3'd5; b_dis_t2 = 3'd0;
        tick(); b_dis_en = 0;
        b_fu_ready = 5'b11111; settle();
        chk("t6_wait_no_iss", 64'(b_iss_valid), 64'h0);
        chk("t6_wait_busy", 64'(b_busy), 64'h08);
        b_fu_ready = 0;
        b_dis_en = 1; b_dis_fu = 3'd4; b_dis_t1 = 3'd0; b_dis_t2 = 3'd5; b_wb_valid = 5'b10000;
        tick(); b_dis_en = 0; b_wb_valid = 0;
        chk("t6_busy", 64'(b_busy), 64'h18);
        b_fu_ready = 5'b10000; settle();
        chk("t6_row4_rdy", 64'(b_iss_valid), 64'h1);
        chk("t6_row4_fu", 64'(b_iss_fu), 64'h4);
        b_fu_ready = 5'b01000; settle();
        chk("t6_row3_woken", 64'(b_iss_fu), 64'h3);
        b_fu_ready = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fust_s_gen
`default_nettype wire

// File: doc/fust_s_gen.md
Name: fust_s_gen

Overview:
- Parametrised scalar functional-unit status table: one row per scalar FU, NUM_FU rows.
- Tracks operand-dependency tags, wakes rows on FU completion broadcasts, and issues one ready row per cycle through a round-robin arbiter.
- Squashes speculative rows on branch mispredict.
- Sits between dispatch (row writes) and the scalar FUs (issue); generalises the fixed 3-row scalar FUST.

Parameters:
- NUM_FU, 3, number of scalar FUs / table rows (2..8)
- FU_IDX_W, $clog2(NUM_FU), row/FU index width
- TAG_W, $clog2(NUM_FU+1), dependency tag width; 0 = operand ready, k = waiting on FU k-1
- REG_W, 5, scalar register index width
- IMM_W, 32, immediate width
- OP_W, 4, op_type width

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dis_en  in  1  dispatch write strobe
- dis_fu  in  FU_IDX_W  target row
- dis_rd / dis_rs1 / dis_rs2  in  REG_W each  register fields
- dis_imm  in  IMM_W  immediate
- dis_op  in  OP_W  op_type
- dis_spec  in  1  instruction is speculative
- dis_t1 / dis_t2  in  TAG_W each  producer tags for rs1/rs2
- wb_valid  in  NUM_FU  completion broadcast, bit k = FU k produced its result this cycle
- fu_ready  in  NUM_FU  FU k can accept an issue
- fu_done  in  NUM_FU  FU k finished; releases its row
- br_resolved  in  1  oldest branch resolved correctly
- br_miss  in  1  branch mispredicted
- busy  out  NUM_FU  row k not EMPTY (to dispatch)
- iss_valid  out  1  issue this cycle
- iss_fu  out  FU_IDX_W  issued row
- iss_rd / iss_rs1 / iss_rs2 / iss_imm / iss_op / iss_spec  out  row fields of issued row
- dis_err  out  1  registered pulse: previous-cycle dispatch rejected

Behaviour:
- Reset (nRST low, async): all rows EMPTY, tags 0, spec 0, RR pointer 0, dis_err 0; hence busy=0, iss_valid=0, and all iss_* fields 0.
- Row state uses fust_state_e: EMPTY, WAIT, RDY, EX.
- Wakeup: at the clock edge, a stored tag t!=0 with wb_valid[t-1]=1 becomes 0.
  - Applies to dispatch-cycle tags too: a dis_t1 matching a same-cycle wb_valid is stored as 0.
- EMPTY -> WAIT/RDY on dispatch. Goes to RDY if both post-wakeup tags are 0, otherwise WAIT.
- WAIT -> RDY when both tags reach 0 (registered; visible the next cycle).
- RDY -> EX when granted: iss_valid=1 and iss_fu=k.
- EX -> EMPTY on fu_done[k].
- fu_done[k] while not in EX: ignored.
- Dispatch to a non-EMPTY row is rejected: row unchanged, dis_err=1 next cycle.
  - Exception: fu_done[k] in the same cycle frees row k, and the dispatch is then accepted.
- Issue (combinational from registered state):
  - Candidates are rows in RDY with fu_ready[k]=1.
  - Round-robin grant starting at the RR pointer; iss_valid=1 if any candidate.
  - On grant, pointer <= (granted+1) mod NUM_FU; otherwise it holds.
  - iss_* fields carry the granted row; all zero when iss_valid=0.
- Latency:
  - Dispatch with ready operands in cycle N gives iss_valid earliest in N+1.
  - wb_valid in N gives the dependent row RDY in N+1 and issue in N+1.
- Speculation:
  - br_resolved clears every row's spec bit.
  - br_miss sets every row with spec=1 to EMPTY, whatever its state. An EX row is squashed and the FU discards its result.
  - A dispatch with dis_spec=1 in the br_miss cycle is dropped without dis_err.
  - br_miss and br_resolved together: br_miss wins.
  - An issue grant in the br_miss cycle still drives iss_valid, but the row is emptied.
- Tag encoding wraps nothing: tags > NUM_FU are illegal and must be covered by an assertion.
- Reset mid-operation clears everything asynchronously; no partial state survives.

Decomposition:
- datapath_pkg gains a parametrised row typedef (rd, rs1, rs2, imm, op, spec, t1, t2, state) built from the parameters above.
- fust_state_e is reused from datapath_pkg.
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr; outputs gnt_valid, gnt_idx. Purely combinational; the pointer register lives in fust_s_gen.

Test Plan:
- Reset then dispatch row 1, t1=t2=0, fu_ready=all 1 -> next cycle busy=3'b010, iss_valid=1, iss_fu=1; fu_done[1] -> busy=0.
- Dispatch row 0 with t1=2; wb_valid=3'b010 two cycles later -> row 0 stays WAIT, iss_valid=0 until the cycle after wb_valid, then iss_fu=0.
- Rows 0, 1, 2 all RDY, fu_ready all 1, held -> grants 0, 1, 2 on successive cycles, then the pointer wraps to 0.
- Rows 0 (spec=1) and 2 (spec=0) occupied, pulse br_miss -> next cycle busy=3'b100; repeat with br_resolved first -> busy unchanged and spec bits 0.
- Dispatch to busy row 2 -> dis_err=1 one cycle, row contents unchanged; same with fu_done[2] in the same cycle -> accepted, dis_err=0.
- NUM_FU=5 build: dispatch row 4 with t2=5, wb_valid=5'b10000 in the same cycle -> row 4 is RDY next cycle.
